// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter for the shared 16:1 mux. Grants are held until the requester
// releases or the hold limit expires. The select output stays stable while no grant is active.
module mux16_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned CNT_W    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] req,
    output logic [3:0]  sel,
    output logic [15:0] gnt,
    output logic        gnt_valid,
    output logic        timeout
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e             state_q, state_d;
    logic [3:0]         ptr_q, ptr_d;
    logic [3:0]         sel_q, sel_d;
    logic [15:0]        gnt_q, gnt_d;
    logic               gnt_valid_q, gnt_valid_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;

    logic               win_found;
    logic [3:0]         win_idx;
    logic [3:0]         cand;

    // Scan starting at the priority pointer; the 4-bit add wraps modulo 16.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < 16; k++) begin
            cand = ptr_q + 4'(k);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        sel_d       = sel_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        hold_cnt_d  = hold_cnt_q;

        unique case (state_q)
            StIdle: begin
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
                if (en && win_found) begin
                    sel_d       = win_idx;
                    gnt_d       = 16'(1) << win_idx;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = CNT_W'(1);
                    state_d     = StGrant;
                end
            end
            StGrant: begin
                // A dropped request wins over the hold limit, so no timeout in that case.
                if (!req[sel_q] || (hold_cnt_q == CNT_W'(MAX_HOLD))) begin
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    ptr_d       = sel_q + 4'd1;
                    hold_cnt_d  = '0;
                    timeout_d   = req[sel_q];
                    state_d     = StIdle;
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            sel_q       <= '0;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            hold_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            sel_q       <= sel_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    assign sel       = sel_q;
    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Directed bench for mux16_rr_arbiter: the driver queues hand-computed per-cycle
// expectations, and a monitor on the falling edge pops and compares them.
module tb_mux16_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] req;
    logic [3:0]  sel;
    logic [15:0] gnt;
    logic        gnt_valid;
    logic        timeout;

    mux16_rr_arbiter #(
        .MAX_HOLD (8),
        .CNT_W    (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .sel       (sel),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  sel;
        logic [15:0] gnt;
        logic        gv;
        logic        to;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   drv_done = 1'b0;

    // Apply inputs for one edge, then queue the outputs expected right after it.
    task automatic cyc(input logic r, input logic e, input logic [15:0] rq,
                       input logic [3:0] esel, input logic egv, input logic eto,
                       input string name);
        exp_t x;
        rst = r;
        en  = e;
        req = rq;
        @(posedge clk);
        #1;
        x.sel  = esel;
        x.gv   = egv;
        x.to   = eto;
        x.gnt  = egv ? (16'(1) << esel) : 16'h0000;
        x.name = name;
        exp_q.push_back(x);
    endtask

    task automatic grant_run(input logic e, input logic [15:0] rq, input logic [3:0] idx,
                             input int n, input string name);
        for (int i = 0; i < n; i++) cyc(1'b0, e, rq, idx, 1'b1, 1'b0, name);
    endtask

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t x;
                x = exp_q.pop_front();
                n_cmp++;
                if (sel !== x.sel || gnt !== x.gnt || gnt_valid !== x.gv || timeout !== x.to) begin
                    n_fail++;
                    $display("FAIL %s: got sel=%0d gnt=%h gv=%b to=%b, want sel=%0d gnt=%h gv=%b to=%b",
                             x.name, sel, gnt, gnt_valid, timeout, x.sel, x.gnt, x.gv, x.to);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        req = 16'h0000;

        // 1: reset, then no requests
        cyc(1'b1, 1'b0, 16'h0000, 4'd0, 1'b0, 1'b0, "reset");
        cyc(1'b1, 1'b1, 16'hFFFF, 4'd0, 1'b0, 1'b0, "reset_with_req");
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 16'h0000, 4'd0, 1'b0, 1'b0, "idle_noreq");

        // 2: two requesters held, each times out after 8 cycles
        grant_run(1'b1, 16'h0041, 4'd0, 8, "hold0");
        cyc(1'b0, 1'b1, 16'h0041, 4'd0, 1'b0, 1'b1, "timeout0");
        grant_run(1'b1, 16'h0041, 4'd6, 8, "hold6");
        cyc(1'b0, 1'b1, 16'h0041, 4'd6, 1'b0, 1'b1, "timeout6");
        grant_run(1'b1, 16'h0041, 4'd0, 1, "back_to0");
        cyc(1'b0, 1'b1, 16'hC000, 4'd0, 1'b0, 1'b0, "release0");

        // 3: early drop on 14, then 15, then wrap to 0
        grant_run(1'b1, 16'hC000, 4'd14, 3, "hold14");
        cyc(1'b0, 1'b1, 16'h8000, 4'd14, 1'b0, 1'b0, "release14");
        grant_run(1'b1, 16'h8000, 4'd15, 1, "grant15");
        cyc(1'b0, 1'b1, 16'h0001, 4'd15, 1'b0, 1'b0, "release15");
        grant_run(1'b1, 16'h0001, 4'd0, 1, "wrap0");
        cyc(1'b0, 1'b1, 16'h0000, 4'd0, 1'b0, 1'b0, "release_wrap0");

        // 4: drop coincides with the hold limit -> plain release
        grant_run(1'b1, 16'h0008, 4'd3, 8, "hold3");
        cyc(1'b0, 1'b1, 16'h0000, 4'd3, 1'b0, 1'b0, "drop_at_limit");
        cyc(1'b0, 1'b1, 16'h0000, 4'd3, 1'b0, 1'b0, "no_late_timeout");

        // 5: en low during grant; grant still runs to timeout, none new until en returns
        grant_run(1'b1, 16'h0004, 4'd2, 1, "grant2");
        grant_run(1'b0, 16'h0024, 4'd2, 7, "hold2_en0");
        cyc(1'b0, 1'b0, 16'h0024, 4'd2, 1'b0, 1'b1, "timeout2_en0");
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 16'h0024, 4'd2, 1'b0, 1'b0, "en0_no_grant");
        grant_run(1'b1, 16'h0024, 4'd5, 1, "grant5");

        // 6: reset during an active grant
        cyc(1'b1, 1'b1, 16'h0024, 4'd0, 1'b0, 1'b0, "reset_mid_grant");
        grant_run(1'b1, 16'h0021, 4'd0, 2, "post_reset_ptr0");
        cyc(1'b0, 1'b1, 16'h0000, 4'd0, 1'b0, 1'b0, "post_reset_release");

        drv_done = 1'b1;
    end

    initial begin
        int budget;
        budget = 0;
        wait (drv_done);
        while (exp_q.size() > 0 && budget < 20) begin
            @(posedge clk);
            budget++;
        end
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want normal completion");
        $fatal(1, "watchdog");
    end

endmodule
